// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between a core and an external
// programmer. Taking over the bus holds the core in reset; giving it back
// keeps the core in reset for RST_HOLD_CYCLES more cycles.
// Optional feature macro: ARB_PROG_READBACK_EN enables programmer reads.
module mem_bus_arbiter #(
  parameter int unsigned RST_HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // core side
  input  logic        core_rd_en_i,
  input  logic        core_wr_en_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_data_i,
  output logic [31:0] core_data_o,
  output logic        core_rst_n_o,
  // programmer side
  input  logic        prog_req_i,
  output logic        prog_gnt_o,
  input  logic        prog_valid_i,
  input  logic        prog_wr_i,
  input  logic [31:0] prog_addr_i,
  input  logic [31:0] prog_wdata_i,
  output logic [31:0] prog_rdata_o,
  output logic        prog_rvalid_o,
  output logic [15:0] prog_wr_count_o,
  // memory side
  output logic        mem_rd_en_o,
  output logic        mem_wr_en_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WCNT_W = 16;

`ifdef ARB_PROG_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  typedef enum logic [1:0] {RUN, HALT, PROG, RELEASE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    hold_cnt;
  logic                core_rst_n_q;
  logic                prog_rvalid_q;
  logic [WCNT_W-1:0]   wr_count_q;

  logic prog_acc;
  logic prog_wr_acc;
  logic prog_rd_acc;

  // Programmer transfers only count while the bus is granted
  assign prog_acc    = (state == PROG) & prog_valid_i;
  assign prog_wr_acc = prog_acc & prog_wr_i;
  assign prog_rd_acc = prog_acc & ~prog_wr_i & READBACK;

  assign core_data_o     = mem_data_i;
  assign core_rst_n_o    = core_rst_n_q;
  assign prog_gnt_o      = rst_n & (state == PROG);
  assign prog_rvalid_o   = prog_rvalid_q;
  assign prog_rdata_o    = READBACK ? mem_data_i : 32'h0;
  assign prog_wr_count_o = wr_count_q;

  // Memory port mux: core in RUN, programmer in PROG, idle otherwise or in reset
  always_comb begin
    mem_rd_en_o = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_addr_o  = 32'h0;
    mem_data_o  = 32'h0;
    if (rst_n) begin
      case (state)
        RUN: begin
          mem_rd_en_o = core_rd_en_i;
          mem_wr_en_o = core_wr_en_i;
          mem_addr_o  = core_addr_i;
          mem_data_o  = core_data_i;
        end
        PROG: begin
          if (prog_acc) begin
            mem_wr_en_o = prog_wr_acc;
            mem_rd_en_o = prog_rd_acc;
            mem_addr_o  = prog_addr_i;
            mem_data_o  = prog_wdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Ownership FSM with core reset hold counter and write statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RELEASE;
      hold_cnt      <= CNT_W'(RST_HOLD_CYCLES);
      core_rst_n_q  <= 1'b0;
      prog_rvalid_q <= 1'b0;
      wr_count_q    <= '0;
    end else begin
      // read data returns the cycle after the access, even if PROG is left
      prog_rvalid_q <= prog_rd_acc;
      case (state)
        RUN: begin
          if (prog_req_i) begin
            state        <= HALT;
            core_rst_n_q <= 1'b0;
            wr_count_q   <= '0;
          end
        end
        HALT: begin
          state <= PROG;
        end
        PROG: begin
          if (prog_wr_acc && (wr_count_q != {WCNT_W{1'b1}})) begin
            wr_count_q <= wr_count_q + WCNT_W'(1);
          end
          if (!prog_req_i) begin
            state    <= RELEASE;
            hold_cnt <= CNT_W'(RST_HOLD_CYCLES);
          end
        end
        RELEASE: begin
          if (prog_req_i) begin
            state <= PROG;
          end else if (hold_cnt == CNT_W'(1)) begin
            state        <= RUN;
            core_rst_n_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
        default: state <= RELEASE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter with a behavioural memory and a
// read-data scoreboard. Follows ARB_PROG_READBACK_EN like the design.
module tb_mem_bus_arbiter;

  localparam int unsigned HOLD = 4;
`ifdef ARB_PROG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_rd_en_i, core_wr_en_i;
  logic [31:0] core_addr_i, core_data_i, core_data_o;
  logic        core_rst_n_o;
  logic        prog_req_i, prog_gnt_o, prog_valid_i, prog_wr_i;
  logic [31:0] prog_addr_i, prog_wdata_i, prog_rdata_o;
  logic        prog_rvalid_o;
  logic [15:0] prog_wr_count_o;
  logic        mem_rd_en_o, mem_wr_en_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_img [0:255];
  logic [31:0] mem [0:255];
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.RST_HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_rd_en_i(core_rd_en_i), .core_wr_en_i(core_wr_en_i),
    .core_addr_i(core_addr_i), .core_data_i(core_data_i),
    .core_data_o(core_data_o), .core_rst_n_o(core_rst_n_o),
    .prog_req_i(prog_req_i), .prog_gnt_o(prog_gnt_o),
    .prog_valid_i(prog_valid_i), .prog_wr_i(prog_wr_i),
    .prog_addr_i(prog_addr_i), .prog_wdata_i(prog_wdata_i),
    .prog_rdata_o(prog_rdata_o), .prog_rvalid_o(prog_rvalid_o),
    .prog_wr_count_o(prog_wr_count_o),
    .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i)
  );

  // Synchronous memory: read data valid the cycle after mem_rd_en_o
  always @(posedge clk) begin
    if (mem_wr_en_o) mem[mem_addr_o[9:2]] <= mem_data_o;
    if (mem_rd_en_o) mem_rdata <= mem[mem_addr_o[9:2]];
  end
  assign mem_data_i = mem_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: every rvalid must match the oldest outstanding read
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (prog_rvalid_o) begin
        if (exp_q.size() == 0) check("rvalid_unexpected", 32'(prog_rvalid_o), 32'h0);
        else check("prog_rdata", prog_rdata_o, exp_q.pop_front());
      end
      check("core_data", core_data_o, mem_rdata);
      if (!RB) check("rdata_const0", prog_rdata_o, 32'h0);
    end
  end

  task automatic prog_write(input logic [31:0] addr, input logic [31:0] data);
    prog_valid_i = 1'b1; prog_wr_i = 1'b1; prog_addr_i = addr; prog_wdata_i = data;
    #1;
    check("wr_en", 32'(mem_wr_en_o), 32'h1);
    check("wr_rd_en", 32'(mem_rd_en_o), 32'h0);
    check("wr_addr", mem_addr_o, addr);
    check("wr_data", mem_data_o, data);
    ref_img[addr[9:2]] = data;
    step();
    prog_valid_i = 1'b0;
  endtask

  task automatic prog_read(input logic [31:0] addr);
    prog_valid_i = 1'b1; prog_wr_i = 1'b0; prog_addr_i = addr;
    #1;
    check("rd_en", 32'(mem_rd_en_o), 32'(RB));
    check("rd_wr_en", 32'(mem_wr_en_o), 32'h0);
    if (RB) exp_q.push_back(ref_img[addr[9:2]]);
    step();
    prog_valid_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0;
      ref_img[i] = 32'h0;
    end
    rst_n = 1'b0;
    core_rd_en_i = 1'b1; core_wr_en_i = 1'b0;
    core_addr_i = 32'h10; core_data_i = 32'h0;
    prog_req_i = 1'b0; prog_valid_i = 1'b0; prog_wr_i = 1'b0;
    prog_addr_i = 32'h0; prog_wdata_i = 32'h0;

    // reset state
    repeat (3) step();
    check("rst_core_rst_n", 32'(core_rst_n_o), 32'h0);
    check("rst_rvalid", 32'(prog_rvalid_o), 32'h0);
    check("rst_wr_count", 32'(prog_wr_count_o), 32'h0);
    check("rst_mem_rd_en", 32'(mem_rd_en_o), 32'h0);
    check("rst_gnt", 32'(prog_gnt_o), 32'h0);

    // release: core held exactly HOLD cycles, then core drives memory
    rst_n = 1'b1;
    #1;
    check("rel_mem_idle", 32'(mem_rd_en_o), 32'h0);
    for (int i = 1; i <= int'(HOLD); i++) begin
      step();
      check("rel_core_rst_n", 32'(core_rst_n_o), 32'(i == int'(HOLD)));
      check("rel_mem_rd_en", 32'(mem_rd_en_o), 32'(i == int'(HOLD)));
    end
    check("run_addr", mem_addr_o, 32'h10);
    check("run_gnt", 32'(prog_gnt_o), 32'h0);

    // core write path in RUN
    core_rd_en_i = 1'b0; core_wr_en_i = 1'b1; core_addr_i = 32'h20; core_data_i = 32'h55AA_0001;
    #1;
    check("run_wr_en", 32'(mem_wr_en_o), 32'h1);
    check("run_wr_data", mem_data_o, 32'h55AA_0001);
    ref_img[8] = 32'h55AA_0001;
    step();
    core_wr_en_i = 1'b0; core_rd_en_i = 1'b1; core_addr_i = 32'h10;

    // takeover: HALT one idle cycle, then grant
    prog_req_i = 1'b1;
    step();
    check("halt_core_rst_n", 32'(core_rst_n_o), 32'h0);
    check("halt_gnt", 32'(prog_gnt_o), 32'h0);
    check("halt_mem_rd_en", 32'(mem_rd_en_o), 32'h0);
    check("halt_wr_count", 32'(prog_wr_count_o), 32'h0);
    step();
    check("prog_gnt", 32'(prog_gnt_o), 32'h1);
    check("prog_core_ignored", 32'(mem_rd_en_o), 32'h0);
    check("prog_core_rst_n", 32'(core_rst_n_o), 32'h0);

    // writes, then readback including back-to-back reads
    prog_write(32'h0, 32'hDEADBEEF);
    check("wr_count1", 32'(prog_wr_count_o), 32'h1);
    prog_write(32'h4, 32'h00000013);
    check("wr_count2", 32'(prog_wr_count_o), 32'h2);
    prog_read(32'h0);
    prog_read(32'h4);
    prog_read(32'h20);
    step();
    check("wr_count_hold", 32'(prog_wr_count_o), 32'h2);

    // read in the final PROG cycle still returns data
    prog_req_i = 1'b0;
    prog_read(32'h0);
    check("release_gnt", 32'(prog_gnt_o), 32'h0);
    // transfer without grant is ignored
    prog_valid_i = 1'b1; prog_wr_i = 1'b1; prog_addr_i = 32'h8; prog_wdata_i = 32'hBAD0_BAD0;
    #1;
    check("nognt_wr_en", 32'(mem_wr_en_o), 32'h0);
    step();
    prog_valid_i = 1'b0;
    check("release2_core_rst_n", 32'(core_rst_n_o), 32'h0);
    // re-request during RELEASE goes straight to PROG
    prog_req_i = 1'b1;
    step();
    check("regrant_gnt", 32'(prog_gnt_o), 32'h1);
    check("regrant_core_rst_n", 32'(core_rst_n_o), 32'h0);
    check("regrant_wr_count", 32'(prog_wr_count_o), 32'h2);
    prog_read(32'h8);

    // reset in the middle of a write burst
    prog_write(32'h30, 32'h1234_5678);
    check("burst_wr_count", 32'(prog_wr_count_o), 32'h3);
    prog_valid_i = 1'b1; prog_wr_i = 1'b1; prog_addr_i = 32'h34; prog_wdata_i = 32'hCAFE_F00D;
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 32'(mem_wr_en_o), 32'h0);
    check("midrst_gnt", 32'(prog_gnt_o), 32'h0);
    step();
    check("midrst_wr_count", 32'(prog_wr_count_o), 32'h0);
    check("midrst_core_rst_n", 32'(core_rst_n_o), 32'h0);
    check("midrst_rvalid", 32'(prog_rvalid_o), 32'h0);
    check("midrst_wr_en2", 32'(mem_wr_en_o), 32'h0);
    prog_valid_i = 1'b0; prog_req_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 1; i <= int'(HOLD); i++) begin
      step();
      check("rerel_core_rst_n", 32'(core_rst_n_o), 32'(i == int'(HOLD)));
    end
    check("rerel_mem_rd_en", 32'(mem_rd_en_o), 32'h1);
    repeat (2) step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
